// File: rtl/da_pkg.sv
// Shared constants and helpers for the DAC output path.
//   DA_W         DAC code width
//   DA_MIDSCALE  code presented on the pins out of reset
//   bitrev12     reverses bit order of a 12-bit code (board DAC pins are wired LSB-first)
package da_pkg;

  localparam int          DA_W        = 12;
  localparam logic [11:0] DA_MIDSCALE = 12'h800;

  function automatic logic [11:0] bitrev12(input logic [11:0] code);
    logic [11:0] r;
    for (int i = 0; i < 12; i++) begin
      r[11-i] = code[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/da_fifo.sv
// Single-clock sample FIFO between the stream input and the pin register.
// Ports:
//   clk, rst_n        clock, async active-low reset (empties the FIFO)
//   push, wr_data     write request / data (ignored while full)
//   pop, rd_data      read request (ignored while empty) / head of queue
//   full, empty       occupancy flags, derived from the registered count
// DEPTH must be a power of two so the pointers wrap naturally.
module da_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/da_out.sv
// DAC output stage: buffers 12-bit sample codes from a valid/ready stream and
// drives them bit-reversed onto the DAC pins, one code per sample tick.
// Ports:
//   da_clk, rst_n   clock, async active-low reset
//   enable          run sample ticks (0 holds pins, rate counter at 0)
//   rate_div        tick period minus one
//   s_data/s_valid/s_ready   sample stream input (s_ready = not full, 0 in reset)
//   da1_out         registered pin bus, da1_out[11-i] = code[i]
//   da_wrt          one-cycle strobe with each new code on the pins
//   underrun        sticky: a tick found the FIFO empty
//   clear           synchronous clear of underrun (a same-cycle underrun wins)
//   underrun_cnt    saturating count of empty ticks (only with DA_UNDERRUN_CNT_EN)
// Build option: define DA_UNDERRUN_CNT_EN to add the underrun_cnt output.
module da_out
  import da_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             da_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate_div,
  input  logic [11:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [11:0]      da1_out,
  output logic             da_wrt,
  output logic             underrun,
  input  logic             clear
`ifdef DA_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  logic             ready_q, ready_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [11:0]      pins_q, pins_d;
  logic             wrt_q, wrt_d;
  logic             unf_q, unf_d;
  logic             fifo_full, fifo_empty;
  logic [DA_W-1:0]  head;
  logic             tick, push, pop, empty_tick;

  // The FIFO flags come from registered state, so a sample pushed in a tick
  // cycle is not visible to that tick (no bypass).
  assign tick       = enable && (cnt_q == rate_div);
  assign s_ready    = ready_q && !fifo_full;
  assign push       = s_valid && s_ready;
  assign pop        = tick && !fifo_empty;
  assign empty_tick = tick && fifo_empty;

  da_fifo #(.DEPTH(DEPTH), .W(DA_W)) u_fifo (
    .clk     (da_clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    ready_d = 1'b1;
    pins_d  = pins_q;
    wrt_d   = 1'b0;
    unf_d   = unf_q && !clear;
    // A shrunk rate_div below the current count restarts the period without a tick.
    if (!enable || tick || (cnt_q > rate_div)) cnt_d = '0;
    else                                       cnt_d = cnt_q + DIV_W'(1);
    if (pop) begin
      pins_d = bitrev12(head);
      wrt_d  = 1'b1;
    end
    if (empty_tick) unf_d = 1'b1;
  end

  always_ff @(posedge da_clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      cnt_q   <= '0;
      pins_q  <= bitrev12(DA_MIDSCALE);
      wrt_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      pins_q  <= pins_d;
      wrt_q   <= wrt_d;
      unf_q   <= unf_d;
    end
  end

  assign da1_out  = pins_q;
  assign da_wrt   = wrt_q;
  assign underrun = unf_q;

`ifdef DA_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // An empty tick in the same cycle as clear restarts the count at 1.
  always_comb begin
    ucnt_d = ucnt_q;
    if (empty_tick) begin
      if (clear)                  ucnt_d = 16'd1;
      else if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end else if (clear) begin
      ucnt_d = '0;
    end
  end

  always_ff @(posedge da_clk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule
